tlut_input_loader: RTL and testbench

//  Controller and staging buffer in front of the tLUT multiplier input register bank.

---
 rtl/tlut_pkg.sv | 13 +
 rtl/tlut_input_loader_if.sv | 27 ++
 rtl/tlut_input_loader.sv | 104 ++++++++++
 tb/tb_tlut_input_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tlut_pkg.sv
// Shared definitions for the tLUT input path: tile geometry defaults and loader states.
package tlut_pkg;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int IN_W = 8;

    typedef enum logic [1:0] {FILL, LOAD, WAIT, DONE} ld_state_t;

    // Counter width that never collapses to zero bits for degenerate ranges.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction
endpackage

// File: rtl/tlut_input_loader_if.sv
// Element-stream, register-bank load and result handshake bundle of the tLUT input loader.
interface tlut_input_loader_if #(
    parameter int ROWS = tlut_pkg::ROWS,
    parameter int COLS = tlut_pkg::COLS,
    parameter int IN_W = tlut_pkg::IN_W
);
    logic                       in_valid;
    logic                       in_ready;
    logic [IN_W-1:0]            in_data;
    logic                       in_last;
    logic                       ld_en;
    logic [ROWS*COLS*IN_W-1:0]  ld_data;
    logic                       res_valid;
    logic                       res_ready;
    logic [15:0]                tile_cnt;
    logic                       err_frame;

    modport master (
        output in_valid, in_data, in_last, res_ready,
        input  in_ready, ld_en, ld_data, res_valid, tile_cnt, err_frame
    );

    modport slave (
        input  in_valid, in_data, in_last, res_ready,
        output in_ready, ld_en, ld_data, res_valid, tile_cnt, err_frame
    );
endinterface

// File: rtl/tlut_input_loader.sv
// Packs a serial element stream into one tile, strobes it into the tLUT register bank,
// waits out the multiplier latency and hands a result-valid to the adder-tree collector.
module tlut_input_loader #(
    parameter int ROWS     = tlut_pkg::ROWS,
    parameter int COLS     = tlut_pkg::COLS,
    parameter int IN_W     = tlut_pkg::IN_W,
    parameter int PIPE_LAT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    tlut_input_loader_if.slave bus
);
    import tlut_pkg::*;

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = clog2_min1(N);
    localparam int LAT_W = clog2_min1(PIPE_LAT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(PIPE_LAT);

    ld_state_t         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [N*IN_W-1:0] tile_buf;
    logic [15:0]       tile_cnt_q;
    logic              err_q;
    logic              accept, tail_clr, done_ack, set_err;
    logic [N-1:0]      wr_en, clr_en;

    // in_ready is also held low while reset is asserted.
    assign bus.in_ready  = rst_n && (state_q == FILL);
    assign bus.ld_en     = (state_q == LOAD);
    assign bus.ld_data   = tile_buf;
    assign bus.res_valid = (state_q == DONE);
    assign bus.tile_cnt  = tile_cnt_q;
    assign bus.err_frame = err_q;

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        lat_d    = lat_q;
        tail_clr = 1'b0;
        done_ack = 1'b0;
        set_err  = 1'b0;
        case (state_q)
            FILL: if (accept) begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = LOAD;
                    set_err = !bus.in_last;
                end else if (bus.in_last) begin
                    idx_d    = '0;
                    state_d  = LOAD;
                    tail_clr = 1'b1;
                end
            end
            LOAD: begin
                lat_d   = LAT_INIT;
                state_d = (PIPE_LAT == 0) ? DONE : WAIT;
            end
            WAIT: begin
                lat_d = lat_q - 1'b1;
                if (lat_q == LAT_W'(1)) state_d = DONE;
            end
            DONE: if (bus.res_ready) begin
                done_ack = 1'b1;
                state_d  = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // One write-enable and one clear per element slot; a short tile zeroes every slot past idx.
    for (genvar i = 0; i < N; i++) begin : g_el
        assign wr_en[i]  = accept && (idx_q == IDX_W'(i));
        assign clr_en[i] = done_ack || (tail_clr && (IDX_W'(i) > idx_q));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n || clr_en[i]) tile_buf[i*IN_W +: IN_W] <= '0;
            else if (wr_en[i])       tile_buf[i*IN_W +: IN_W] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FILL;
            idx_q      <= '0;
            lat_q      <= '0;
            tile_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            if (done_ack) tile_cnt_q <= tile_cnt_q + 16'd1;
            if (set_err)  err_q      <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tlut_input_loader.sv
// Directed bench for tlut_input_loader: one PIPE_LAT=3 instance and one PIPE_LAT=0 instance.
module tb_tlut_input_loader;
    import tlut_pkg::*;

    localparam int N  = ROWS * COLS;
    localparam int DW = N * IN_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tlut_input_loader_if a_if ();
    tlut_input_loader_if b_if ();

    tlut_input_loader #(.PIPE_LAT(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    tlut_input_loader #(.PIPE_LAT(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

    int vectors = 0;
    int miscompares = 0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [IN_W-1:0] d, input logic last);
        a_if.in_valid = 1'b1;
        a_if.in_data  = d;
        a_if.in_last  = last;
        check1("a_in_ready_fill", a_if.in_ready, 1'b1);
        tick();
        a_if.in_valid = 1'b0;
        a_if.in_last  = 1'b0;
    endtask

    task automatic send_b(input logic [IN_W-1:0] d, input logic last);
        b_if.in_valid = 1'b1;
        b_if.in_data  = d;
        b_if.in_last  = last;
        check1("b_in_ready_fill", b_if.in_ready, 1'b1);
        tick();
        b_if.in_valid = 1'b0;
        b_if.in_last  = 1'b0;
    endtask

    task automatic wait_res_a(input int bound);
        int n = 0;
        while (!a_if.res_valid && n < bound) begin
            tick();
            n++;
        end
        check1("a_res_valid_timeout", a_if.res_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp;
        int gap;

        a_if.in_valid = 0; a_if.in_data = '0; a_if.in_last = 0; a_if.res_ready = 0;
        b_if.in_valid = 0; b_if.in_data = '0; b_if.in_last = 0; b_if.res_ready = 0;

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check1("rst_in_ready_low", a_if.in_ready, 1'b0);
        rst_n = 1'b1;
        tick();
        check1("rst_in_ready", a_if.in_ready, 1'b1);
        check1("rst_ld_en", a_if.ld_en, 1'b0);
        checkw("rst_ld_data", a_if.ld_data, '0);
        check1("rst_res_valid", a_if.res_valid, 1'b0);
        checkw("rst_tile_cnt", DW'(a_if.tile_cnt), DW'(0));
        check1("rst_err_frame", a_if.err_frame, 1'b0);

        // 1: full tile 1..16, res_valid 4 cycles after ld_en
        a_if.res_ready = 1'b1;
        for (int i = 0; i < N; i++) send_a(IN_W'(i + 1), i == N - 1);
        exp = '0;
        for (int i = 0; i < N; i++) exp[i*IN_W +: IN_W] = IN_W'(i + 1);
        check1("t1_ld_en", a_if.ld_en, 1'b1);
        checkw("t1_ld_data", a_if.ld_data, exp);
        check1("t1_in_ready_load", a_if.in_ready, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check1("t1_res_valid_early", a_if.res_valid, 1'b0);
            check1("t1_ld_en_single", a_if.ld_en, 1'b0);
        end
        tick();
        check1("t1_res_valid", a_if.res_valid, 1'b1);
        checkw("t1_tile_cnt_pre", DW'(a_if.tile_cnt), DW'(0));
        tick();
        checkw("t1_tile_cnt", DW'(a_if.tile_cnt), DW'(1));
        check1("t1_in_ready_back", a_if.in_ready, 1'b1);
        checkw("t1_buf_cleared", a_if.ld_data, '0);
        check1("t1_res_valid_drop", a_if.res_valid, 1'b0);

        // 2: short tile of five 9s
        for (int i = 0; i < 5; i++) send_a(IN_W'(9), i == 4);
        exp = '0;
        for (int i = 0; i < 5; i++) exp[i*IN_W +: IN_W] = IN_W'(9);
        check1("t2_ld_en", a_if.ld_en, 1'b1);
        checkw("t2_ld_data", a_if.ld_data, exp);
        check1("t2_err_frame", a_if.err_frame, 1'b0);
        wait_res_a(10);
        tick();
        checkw("t2_tile_cnt", DW'(a_if.tile_cnt), DW'(2));

        // 3 + 4: missing in_last, then result held back for 10 cycles
        a_if.res_ready = 1'b0;
        for (int i = 0; i < N; i++) send_a(IN_W'(8'h20 + i), 1'b0);
        exp = '0;
        for (int i = 0; i < N; i++) exp[i*IN_W +: IN_W] = IN_W'(8'h20 + i);
        check1("t3_err_frame", a_if.err_frame, 1'b1);
        check1("t3_ld_en", a_if.ld_en, 1'b1);
        checkw("t3_ld_data", a_if.ld_data, exp);
        wait_res_a(10);
        for (int k = 0; k < 10; k++) begin
            tick();
            check1("t4_res_valid_hold", a_if.res_valid, 1'b1);
            check1("t4_in_ready_hold", a_if.in_ready, 1'b0);
            checkw("t4_tile_cnt_hold", DW'(a_if.tile_cnt), DW'(2));
        end
        a_if.res_ready = 1'b1;
        tick();
        checkw("t4_tile_cnt", DW'(a_if.tile_cnt), DW'(3));
        check1("t4_err_sticky", a_if.err_frame, 1'b1);
        check1("t4_in_ready", a_if.in_ready, 1'b1);

        // 5: reset pulse during WAIT drops the tile
        for (int i = 0; i < N; i++) send_a(IN_W'(i), i == N - 1);
        check1("t5_ld_en", a_if.ld_en, 1'b1);
        tick();
        check1("t5_in_wait", a_if.res_valid, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check1("t5_res_valid", a_if.res_valid, 1'b0);
        checkw("t5_tile_cnt", DW'(a_if.tile_cnt), DW'(0));
        check1("t5_err_cleared", a_if.err_frame, 1'b0);
        checkw("t5_ld_data", a_if.ld_data, '0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check1("t5_no_ld_en", a_if.ld_en, 1'b0);
            check1("t5_no_res_valid", a_if.res_valid, 1'b0);
            check1("t5_in_ready", a_if.in_ready, 1'b1);
        end

        // 6: PIPE_LAT=0 instance
        b_if.res_ready = 1'b1;
        for (int i = 0; i < N; i++) send_b(IN_W'(N - i), i == N - 1);
        exp = '0;
        for (int i = 0; i < N; i++) exp[i*IN_W +: IN_W] = IN_W'(N - i);
        check1("t6_ld_en", b_if.ld_en, 1'b1);
        checkw("t6_ld_data", b_if.ld_data, exp);
        tick();
        check1("t6_res_valid", b_if.res_valid, 1'b1);
        check1("t6_in_ready_done", b_if.in_ready, 1'b0);
        tick();
        checkw("t6_tile_cnt", DW'(b_if.tile_cnt), DW'(1));
        check1("t6_in_ready", b_if.in_ready, 1'b1);
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < N; i++) send_b(IN_W'(i + t), i == N - 1);
            gap = 0;
            while (!b_if.in_ready && gap < 10) begin
                gap++;
                tick();
            end
            checkw("t6_in_ready_gap", DW'(gap), DW'(2));
        end
        checkw("t6_tile_cnt_b2b", DW'(b_if.tile_cnt), DW'(3));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
